// File: rtl/relu_maxpool2x2_stream_pkg.sv
// relu_maxpool2x2_stream_pkg: shared fp32 constants and pooling FSM state type
package relu_maxpool2x2_stream_pkg;
    localparam int SIGN_BIT = 31;
    localparam logic [31:0] FP32_ZERO = 32'h0;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
    typedef enum logic {FILL, EMIT} state_t;
endpackage

// File: rtl/relu_maxpool2x2_stream_relu_max_fp32.sv
// relu_max_fp32: ReLU on two fp32 operands, then max by unsigned bit-pattern compare
module relu_max_fp32
    import relu_maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    logic [DATA_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rb;
    // clamp negatives (sign set) to +0; non-negative floats order like unsigned ints
    always_comb begin
        ra = a[SIGN_BIT] ? FP32_ZERO : a;
        rb = b[SIGN_BIT] ? FP32_ZERO : b;
        y = ra > rb ? ra : rb;
    end
endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// relu_maxpool2x2_stream: ReLU followed by 2x2 stride-2 max pooling on a raster pixel stream
module relu_maxpool2x2_stream
    import relu_maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH = 56,
    parameter int HEIGHT = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);
    localparam int HW = WIDTH / 2;
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int IW = HW > 1 ? $clog2(HW) : 1;

    if (WIDTH % 2 != 0 || HEIGHT % 2 != 0) begin : g_cfg_err
        $error("relu_maxpool2x2_stream: WIDTH and HEIGHT must be even");
    end

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] h;
    logic [DATA_WIDTH-1:0] v;
    logic [DATA_WIDTH-1:0] lb_rd;
    logic [DATA_WIDTH-1:0] linebuf [HW];
    logic [IW-1:0]         idx;
    logic                  last_col;
    logic                  last_row;

    assign idx = IW'(col >> 1);
    assign last_col = col == CW'(WIDTH - 1);
    assign last_row = row == RW'(HEIGHT - 1);
    assign lb_rd = linebuf[idx];

    relu_max_fp32 #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (.a(hold), .b(data_in), .y(h));
    relu_max_fp32 #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (.a(lb_rd), .b(h), .y(v));

    // even rows park each horizontal pair max for the odd row below
    always_ff @(posedge clk) begin
        if (valid_in && col[0] && state == FILL) linebuf[idx] <= h;
    end

    // raster counters, row-parity FSM, even-column hold and registered pooled output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            col <= '0;
            row <= '0;
            hold <= FP32_ZERO;
            data_out <= FP32_ZERO;
            valid_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) row <= last_row ? '0 : row + 1'b1;
                if (last_col) state <= state == FILL ? EMIT : FILL;
                if (!col[0]) hold <= data_in[SIGN_BIT] ? FP32_ZERO : data_in;
                if (col[0] && state == EMIT) begin
                    data_out <= v;
                    valid_out <= 1'b1;
                    frame_done <= last_col && last_row;
                end
            end
        end
    end
endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// tb_relu_maxpool2x2_stream: pixel-level pooling model checked every cycle against 2x2, 4x4 and 56x56 instances
module tb_relu_maxpool2x2_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = 32'h0;
    logic        vin = 1'b0;
    int          sel = 0;
    logic [2:0]  vbus;
    logic [2:0]  vout;
    logic [2:0]  fd;
    logic [31:0] dout [3];

    int          checks = 0;
    int          errors = 0;
    int          ws [3];
    int          hs [3];
    int          r [3];
    int          c [3];
    logic [31:0] prv [3][56];
    logic [31:0] cur [3][56];
    logic [2:0]  exp_v, exp_fd, chk_v, chk_fd;
    logic [31:0] exp_d [3];
    logic [31:0] chk_d [3];
    logic [31:0] cap [3][$];
    int          cnt_v [3];
    int          cnt_fd [3];
    logic [31:0] fr1 [16];
    logic [31:0] lit [4];

    always #5 clk = ~clk;
    assign vbus = vin ? (3'b001 << sel) : 3'b000;

    relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2)) u0 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(vbus[0]),
        .data_out(dout[0]), .valid_out(vout[0]), .frame_done(fd[0]));
    relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(vbus[1]),
        .data_out(dout[1]), .valid_out(vout[1]), .frame_done(fd[1]));
    relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) u2 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(vbus[2]),
        .data_out(dout[2]), .valid_out(vout[2]), .frame_done(fd[2]));

    task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, id, a, e, $time);
        end
    endtask

    function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b);
        return a > b ? a : b;
    endfunction

    // expectation for a pixel captured at this edge is checked on the following negedge
    always @(posedge clk) begin
        chk_v <= exp_v;
        chk_fd <= exp_fd;
        for (int i = 0; i < 3; i++) chk_d[i] <= exp_d[i];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("valid_out", i, {31'b0, vout[i]}, rst ? 32'h0 : {31'b0, chk_v[i]});
            chk("frame_done", i, {31'b0, fd[i]}, rst ? 32'h0 : {31'b0, chk_fd[i]});
            chk("data_out", i, dout[i], rst ? 32'h0 : chk_d[i]);
            if (!rst && vout[i]) begin
                cap[i].push_back(dout[i]);
                cnt_v[i]++;
            end
            if (!rst && fd[i]) cnt_fd[i]++;
        end
    end

    task automatic px(input int id, input logic [31:0] d);
        logic [31:0] rv;
        @(posedge clk);
        #1;
        data_in = d;
        sel = id;
        vin = 1'b1;
        exp_v = 3'b0;
        exp_fd = 3'b0;
        rv = d[31] ? 32'h0 : d;
        if (r[id] % 2 == 0) prv[id][c[id]] = rv;
        else begin
            cur[id][c[id]] = rv;
            if (c[id] % 2 == 1) begin
                exp_v[id] = 1'b1;
                exp_d[id] = mx(mx(prv[id][c[id]-1], prv[id][c[id]]), mx(cur[id][c[id]-1], rv));
                exp_fd[id] = r[id] == hs[id] - 1 && c[id] == ws[id] - 1;
            end
        end
        if (c[id] == ws[id] - 1) begin
            c[id] = 0;
            r[id] = r[id] == hs[id] - 1 ? 0 : r[id] + 1;
        end else c[id]++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vin = 1'b0;
            data_in = $urandom;
            exp_v = 3'b0;
            exp_fd = 3'b0;
        end
    endtask

    task automatic reset2();
        @(posedge clk);
        #1;
        rst = 1'b1;
        vin = 1'b0;
        exp_v = 3'b0;
        exp_fd = 3'b0;
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 32'h0;
            r[i] = 0;
            c[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic frame1(input bit gaps);
        for (int k = 0; k < 16; k++) begin
            if (gaps) while ($urandom_range(99) < 30) idle(1);
            px(1, fr1[k]);
        end
        idle(2);
    endtask

    task automatic check_lit(input string nm);
        chk({nm, "_count"}, 1, cap[1].size(), 4);
        for (int i = 0; i < 4 && i < cap[1].size(); i++) chk(nm, 1, cap[1][i], lit[i]);
    endtask

    initial begin
        ws = '{2, 4, 56};
        hs = '{2, 4, 56};
        fr1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        lit = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        exp_v = 3'b0;
        exp_fd = 3'b0;
        for (int i = 0; i < 3; i++) begin
            exp_d[i] = 32'h0;
            r[i] = 0;
            c[i] = 0;
            cnt_v[i] = 0;
            cnt_fd[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", 1, {31'b0, vout[1]}, 32'h0);
        chk("reset_data", 1, dout[1], 32'h0);

        frame1(1'b0);
        check_lit("t1_pool");
        chk("t1_frame_done", 1, cnt_fd[1], 1);

        cap[1].delete();
        for (int k = 0; k < 16; k++) px(1, k % 2 == 0 ? 32'hBF800000 : 32'h80000000);
        idle(2);
        chk("t2_count", 1, cap[1].size(), 4);
        for (int i = 0; i < cap[1].size(); i++) chk("t2_zero", 1, cap[1][i], 32'h0);

        px(0, 32'hBF800000);
        px(0, 32'h3F000000);
        px(0, 32'h40200000);
        px(0, 32'hC0400000);
        idle(2);
        chk("t3_count", 0, cap[0].size(), 1);
        if (cap[0].size() > 0) chk("t3_pool", 0, cap[0][0], 32'h40200000);

        cap[1].delete();
        frame1(1'b1);
        check_lit("t4_gaps");

        for (int k = 0; k < 6; k++) px(1, fr1[k]);
        idle(1);
        reset2();
        cap[1].delete();
        frame1(1'b0);
        check_lit("t5_reset");

        for (int i = 0; i < 3; i++) begin
            cnt_v[i] = 0;
            cnt_fd[i] = 0;
        end
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 56 * 56; k++) px(2, $urandom);
        idle(3);
        chk("t6_valid_count", 2, cnt_v[2], 1568);
        chk("t6_frame_done", 2, cnt_fd[2], 2);
        chk("t6_other_quiet", 1, cnt_v[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
